// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Holds the FSM state encoding, MIPS MULT/DIV funct codes and counter widths.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } stall_state_t;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int MW_CNT_W = 8;
    localparam int STAT_W   = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic is_muldiv_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_muldiv_timer.sv
// Loadable down-counter timing the EXE occupancy of a MULT/DIV instruction.
// o_done flags the final stall cycle (value of one).
module muldiv_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_value,
    output logic         o_done
);

    logic [W-1:0] r_value;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_dec && (r_value != '0)) begin
            r_value <= r_value - W'(1);
        end
    end

    assign o_value = r_value;
    assign o_done  = (r_value == W'(1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/bubble/flush sequencer for the 5-stage MIPS pipeline.
// Optional per-source stall statistics are built when STALL_STATS_EN is defined.
//
// state   | meaning
// RUN     | normal flow; hazard/branch/new MULT-DIV handled here
// MD_BUSY | MULT/DIV occupying EXE, pipe frozen behind it
// MD_DONE | release cycle; same MULT/DIV still in EXE, not restarted
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_is_hazard_detected,
    input  logic i_branch_taken,
    input  logic i_muldiv_start,
    input  logic i_muldiv_is_div,
    input  logic i_mem_req,
    input  logic i_mem_ready,
    output logic o_freeze_PC,
    output logic o_freeze_IF_ID,
    output logic o_flush_IF_ID,
    output logic o_freeze_ID_EXE,
    output logic o_bubble_ID_EXE,
    output logic o_freeze_EXE_MEM,
    output logic o_bubble_EXE_MEM,
    output logic o_muldiv_done,
    output logic o_mem_timeout_err
`ifdef STALL_STATS_EN
    ,
    output logic [STAT_W-1:0] o_hazard_stall_cnt,
    output logic [STAT_W-1:0] o_muldiv_stall_cnt,
    output logic [STAT_W-1:0] o_mem_stall_cnt,
    output logic [STAT_W-1:0] o_flush_cnt
`endif
);

    localparam int TMR_W = cnt_width(max_int(MUL_LAT, DIV_LAT));
    localparam logic [TMR_W-1:0] MUL_LOAD = TMR_W'(MUL_LAT - 1);
    localparam logic [TMR_W-1:0] DIV_LOAD = TMR_W'(DIV_LAT - 1);
    localparam logic [MW_CNT_W-1:0] MW_LIMIT = MW_CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] S_RUN     = RUN;
    localparam logic [1:0] S_MD_BUSY = MD_BUSY;
    localparam logic [1:0] S_MD_DONE = MD_DONE;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [MW_CNT_W-1:0] r_mw_cnt;
    logic                r_timeout_err;

    logic w_mem_wait;
    logic w_timeout_hit;
    logic w_mem_stall;
    logic w_md_start;
    logic w_md_stall;
    logic w_md_done;
    logic w_hz_stall;
    logic w_br_flush;
    logic w_lat_one;

    logic             w_tmr_dec;
    logic             w_tmr_done;
    logic [TMR_W-1:0] w_tmr_load_val;
    logic [TMR_W-1:0] w_tmr_value;

    assign w_mem_wait     = i_mem_req & ~i_mem_ready;
    assign w_timeout_hit  = w_mem_wait & (r_mw_cnt == MW_LIMIT);
    assign w_mem_stall    = w_mem_wait & ~w_timeout_hit;
    assign w_tmr_load_val = i_muldiv_is_div ? DIV_LOAD : MUL_LOAD;
    assign w_lat_one      = i_muldiv_is_div ? (DIV_LAT == 1) : (MUL_LAT == 1);

    // Source selection; a memory stall blocks new work but not the MULT/DIV countdown.
    always_comb begin
        w_next_state = r_state;
        w_md_start   = 1'b0;
        w_md_stall   = 1'b0;
        w_md_done    = 1'b0;
        w_hz_stall   = 1'b0;
        w_br_flush   = 1'b0;
        w_tmr_dec    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (!w_mem_stall) begin
                    if (i_muldiv_start) begin
                        w_md_start = 1'b1;
                        w_md_stall = 1'b1;
                        if (w_lat_one) begin
                            w_md_done    = 1'b1;
                            w_next_state = S_MD_DONE;
                        end else begin
                            w_next_state = S_MD_BUSY;
                        end
                    end else if (i_is_hazard_detected) begin
                        w_hz_stall = 1'b1;
                    end else if (i_branch_taken) begin
                        w_br_flush = 1'b1;
                    end
                end
            end
            S_MD_BUSY: begin
                w_md_stall = 1'b1;
                w_tmr_dec  = 1'b1;
                if (w_tmr_done) begin
                    w_md_done    = 1'b1;
                    w_next_state = S_MD_DONE;
                end
            end
            S_MD_DONE: begin
                if (!w_mem_stall) begin
                    if (i_is_hazard_detected) begin
                        w_hz_stall = 1'b1;
                    end else if (i_branch_taken) begin
                        w_br_flush = 1'b1;
                    end
                    w_next_state = S_RUN;
                end
            end
            default: w_next_state = S_RUN;
        endcase
    end

    always_comb begin
        o_freeze_PC       = 1'b0;
        o_freeze_IF_ID    = 1'b0;
        o_flush_IF_ID     = 1'b0;
        o_freeze_ID_EXE   = 1'b0;
        o_bubble_ID_EXE   = 1'b0;
        o_freeze_EXE_MEM  = 1'b0;
        o_bubble_EXE_MEM  = 1'b0;
        o_muldiv_done     = 1'b0;
        o_mem_timeout_err = 1'b0;
        if (!i_rst) begin
            if (w_mem_stall) begin
                o_freeze_PC      = 1'b1;
                o_freeze_IF_ID   = 1'b1;
                o_freeze_ID_EXE  = 1'b1;
                o_freeze_EXE_MEM = 1'b1;
            end else begin
                if (w_md_stall) begin
                    o_freeze_PC      = 1'b1;
                    o_freeze_IF_ID   = 1'b1;
                    o_freeze_ID_EXE  = 1'b1;
                    o_bubble_EXE_MEM = 1'b1;
                end
                if (w_hz_stall) begin
                    o_freeze_PC     = 1'b1;
                    o_freeze_IF_ID  = 1'b1;
                    o_bubble_ID_EXE = 1'b1;
                end
                if (w_br_flush) begin
                    o_flush_IF_ID = 1'b1;
                end
            end
            o_muldiv_done     = w_md_done;
            o_mem_timeout_err = r_timeout_err;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_mw_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_mw_cnt <= w_mem_stall ? (r_mw_cnt + MW_CNT_W'(1)) : '0;
            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    muldiv_timer #(
        .W (TMR_W)
    ) u_muldiv_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_md_start),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_value    (w_tmr_value),
        .o_done     (w_tmr_done)
    );

`ifdef STALL_STATS_EN
    logic [STAT_W-1:0] r_hazard_stall_cnt;
    logic [STAT_W-1:0] r_muldiv_stall_cnt;
    logic [STAT_W-1:0] r_mem_stall_cnt;
    logic [STAT_W-1:0] r_flush_cnt;

    // A cycle is credited to whichever source actually drove the pipe controls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hazard_stall_cnt <= '0;
            r_muldiv_stall_cnt <= '0;
            r_mem_stall_cnt    <= '0;
            r_flush_cnt        <= '0;
        end else begin
            if (w_mem_stall && (r_mem_stall_cnt != '1)) begin
                r_mem_stall_cnt <= r_mem_stall_cnt + STAT_W'(1);
            end
            if (!w_mem_stall && w_md_stall && (r_muldiv_stall_cnt != '1)) begin
                r_muldiv_stall_cnt <= r_muldiv_stall_cnt + STAT_W'(1);
            end
            if (!w_mem_stall && w_hz_stall && (r_hazard_stall_cnt != '1)) begin
                r_hazard_stall_cnt <= r_hazard_stall_cnt + STAT_W'(1);
            end
            if (!w_mem_stall && w_br_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + STAT_W'(1);
            end
        end
    end

    assign o_hazard_stall_cnt = i_rst ? '0 : r_hazard_stall_cnt;
    assign o_muldiv_stall_cnt = i_rst ? '0 : r_muldiv_stall_cnt;
    assign o_mem_stall_cnt    = i_rst ? '0 : r_mem_stall_cnt;
    assign o_flush_cnt        = i_rst ? '0 : r_flush_cnt;
`endif

    logic w_unused;
    assign w_unused = ^w_tmr_value;

endmodule
